oflow_apb_cfg_bank: RTL and testbench

// Parametrised APB configuration bank for the oflow core. It supersedes the fixed weight register file.
// NUM_REGS uniform RW shadow registers feed a double-buffered active bank, which the core consumes.

---
 rtl/oflow_apb_cfg_bank.sv | 189 ++++++++++++++++++
 tb/tb_oflow_apb_cfg_bank.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/oflow_apb_cfg_bank.sv
// APB configuration bank: NUM_REGS RW shadow registers committed to an active bank on frame_start,
// plus STATUS/CTRL words, programmable wait states and PSLVERR for unmapped or misaligned accesses.
module oflow_apb_cfg_bank #(
    parameter int unsigned NUM_REGS    = 8,
    parameter int unsigned REG_W       = 8,
    parameter int unsigned ADDR_LEN    = 10,
    parameter int unsigned BASE_ADDR   = 0,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic                      clk,
    input  logic                      reset_N,
    input  logic                      apb_psel,
    input  logic                      apb_penable,
    input  logic                      apb_pwrite,
    input  logic [ADDR_LEN-1:0]       apb_addr,
    input  logic [31:0]               apb_pwdata,
    output logic                      apb_pready,
    output logic [31:0]               apb_prdata,
    output logic                      apb_pslverr,
    input  logic                      frame_start,
    input  logic [31:0]               status_in,
    output logic [NUM_REGS*REG_W-1:0] active_cfg,
    output logic                      commit_done
);

    localparam int unsigned      IDX_W      = ADDR_LEN - 2;
    localparam logic [IDX_W-1:0] STATUS_IDX = IDX_W'(NUM_REGS);
    localparam logic [IDX_W-1:0] CTRL_IDX   = IDX_W'(NUM_REGS + 1);
    localparam logic [2:0]       WS_LAST    = 3'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t                    state;
    state_t                    state_next;
    logic [2:0]                wait_cnt;
    logic [ADDR_LEN-1:0]       addr_q;
    logic                      write_q;
    logic [31:0]               wdata_q;

    logic [REG_W-1:0]          shadow [NUM_REGS];
    logic [NUM_REGS*REG_W-1:0] active_q;
    logic                      pending;
    logic                      commit_done_q;

    logic                      setup;
    logic                      resp;
    logic [ADDR_LEN-1:0]       off;
    logic [IDX_W-1:0]          idx;
    logic                      mapped;
    logic                      hit_shadow;
    logic                      hit_status;
    logic                      hit_ctrl;
    logic                      err;
    logic                      do_write;
    logic                      set_req;
    logic                      commit_fire;
    logic [31:0]               rdata_mux;

    // Write data above REG_W (other than the CTRL bits) is intentionally dropped.
    logic unused_wdata;
    assign unused_wdata = &{1'b0, wdata_q};

    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (apb_psel && !apb_penable) begin
                    state_next = (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!apb_psel) begin
                    state_next = ST_IDLE;
                end else if (wait_cnt == WS_LAST) begin
                    state_next = ST_RESP;
                end
            end
            ST_RESP: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    assign setup = (state == ST_IDLE) && apb_psel && !apb_penable;
    assign resp  = (state == ST_RESP);

    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            addr_q   <= '0;
            write_q  <= 1'b0;
            wdata_q  <= '0;
            wait_cnt <= '0;
        end else if (setup) begin
            addr_q   <= apb_addr;
            write_q  <= apb_pwrite;
            wdata_q  <= apb_pwdata;
            wait_cnt <= '0;
        end else if (state == ST_WAIT) begin
            wait_cnt <= wait_cnt + 3'd1;
        end
    end

    // BASE_ADDR is word aligned, so alignment can be judged on the offset.
    assign off        = addr_q - ADDR_LEN'(BASE_ADDR);
    assign idx        = off[ADDR_LEN-1:2];
    assign mapped     = (addr_q >= ADDR_LEN'(BASE_ADDR)) && (off[1:0] == 2'b00);
    assign hit_shadow = mapped && (idx < STATUS_IDX);
    assign hit_status = mapped && (idx == STATUS_IDX);
    assign hit_ctrl   = mapped && (idx == CTRL_IDX);

    assign err = write_q ? !(hit_shadow || (hit_ctrl && !wdata_q[1]))
                         : !(hit_shadow || hit_status || hit_ctrl);

    assign do_write    = resp && write_q && !err;
    assign set_req     = do_write && hit_ctrl && wdata_q[0];
    assign commit_fire = frame_start && pending;

    always_comb begin
        rdata_mux = '0;
        if (hit_status) begin
            rdata_mux = status_in;
        end
        if (hit_ctrl) begin
            rdata_mux = {30'd0, pending, 1'b0};
        end
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (hit_shadow && (idx == IDX_W'(i))) begin
                rdata_mux = 32'(shadow[i]);
            end
        end
    end

    // Response is registered out of RESP, so the bus sees it one cycle later.
    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            apb_pready  <= 1'b0;
            apb_prdata  <= '0;
            apb_pslverr <= 1'b0;
        end else begin
            apb_pready  <= resp;
            apb_prdata  <= (resp && !write_q && !err) ? rdata_mux : '0;
            apb_pslverr <= resp && err;
        end
    end

    // Commit reads the pre-write shadow; a same-cycle COMMIT_REQ re-arms PENDING.
    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                shadow[i] <= '0;
            end
            active_q      <= '0;
            pending       <= 1'b0;
            commit_done_q <= 1'b0;
        end else begin
            commit_done_q <= commit_fire;
            if (commit_fire) begin
                for (int unsigned i = 0; i < NUM_REGS; i++) begin
                    active_q[i*REG_W +: REG_W] <= shadow[i];
                end
            end
            if (set_req) begin
                pending <= 1'b1;
            end else if (commit_fire) begin
                pending <= 1'b0;
            end
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if (do_write && hit_shadow && (idx == IDX_W'(i))) begin
                    shadow[i] <= wdata_q[REG_W-1:0];
                end
            end
        end
    end

    assign active_cfg  = active_q;
    assign commit_done = commit_done_q;

endmodule

// File: tb/tb_oflow_apb_cfg_bank.sv
// Directed bench for oflow_apb_cfg_bank: vector table of APB accesses plus hand-written
// commit, collision and mid-transfer reset sequences.
module tb_oflow_apb_cfg_bank;

    logic        clk;
    logic        reset_N;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [9:0]  addr;
    logic [31:0] pwdata;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;
    logic        frame_start;
    logic [31:0] status_in;
    logic [63:0] active_cfg;
    logic        commit_done;

    int n_cmp = 0;
    int n_bad = 0;

    oflow_apb_cfg_bank #(
        .NUM_REGS   (8),
        .REG_W      (8),
        .ADDR_LEN   (10),
        .BASE_ADDR  (0),
        .WAIT_STATES(1)
    ) dut (
        .clk        (clk),
        .reset_N    (reset_N),
        .apb_psel   (psel),
        .apb_penable(penable),
        .apb_pwrite (pwrite),
        .apb_addr   (addr),
        .apb_pwdata (pwdata),
        .apb_pready (pready),
        .apb_prdata (prdata),
        .apb_pslverr(pslverr),
        .frame_start(frame_start),
        .status_in  (status_in),
        .active_cfg (active_cfg),
        .commit_done(commit_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: got no end of test, required finish within 1ms");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic        wr;
        logic [9:0]  a;
        logic [31:0] d;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vecs [16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // One APB transfer; frame_start is pulsed in cycle fs_cycle (0 = SETUP cycle, -1 = never).
    task automatic apb(input logic wr, input logic [9:0] a, input logic [31:0] d, input int fs_cycle,
                       output logic [31:0] rd, output logic err, output int lat,
                       output logic cd, output logic late_rdy);
        int n;
        rd = '0; err = 1'b0; lat = -1; cd = 1'b0;
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; addr = a; pwdata = d;
        frame_start = (fs_cycle == 0);
        n = 0;
        while (n < 20) begin
            @(posedge clk); #1;
            n++;
            penable = 1'b1;
            frame_start = (n == fs_cycle);
            cd = cd | commit_done;
            if (pready) begin
                lat = n; rd = prdata; err = pslverr;
                break;
            end
        end
        @(posedge clk); #1;
        late_rdy = pready;
        cd = cd | commit_done;
        psel = 1'b0; penable = 1'b0; frame_start = 1'b0;
    endtask

    task automatic frame_pulse();
        @(posedge clk); #1;
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
    endtask

    logic [31:0] rd;
    logic        err;
    int          lat;
    logic        cd;
    logic        late;

    initial begin
        vecs[0]  = '{1'b1, 10'h008, 32'h0000_01A5, 32'h0000_0000, 1'b0};
        vecs[1]  = '{1'b0, 10'h008, 32'h0,         32'h0000_00A5, 1'b0};
        vecs[2]  = '{1'b0, 10'h028, 32'h0,         32'h0000_0000, 1'b1};
        vecs[3]  = '{1'b1, 10'h020, 32'h0000_1234, 32'h0000_0000, 1'b1};
        vecs[4]  = '{1'b1, 10'h003, 32'h0000_00FF, 32'h0000_0000, 1'b1};
        vecs[5]  = '{1'b0, 10'h003, 32'h0,         32'h0000_0000, 1'b1};
        vecs[6]  = '{1'b0, 10'h000, 32'h0,         32'h0000_0000, 1'b0};
        vecs[7]  = '{1'b0, 10'h020, 32'h0,         32'hDEAD_BEEF, 1'b0};
        vecs[8]  = '{1'b1, 10'h024, 32'h0000_0002, 32'h0000_0000, 1'b1};
        vecs[9]  = '{1'b0, 10'h024, 32'h0,         32'h0000_0000, 1'b0};
        vecs[10] = '{1'b1, 10'h01C, 32'hFFFF_FF5A, 32'h0000_0000, 1'b0};
        vecs[11] = '{1'b0, 10'h01C, 32'h0,         32'h0000_005A, 1'b0};
        vecs[12] = '{1'b0, 10'h3FC, 32'h0,         32'h0000_0000, 1'b1};
        vecs[13] = '{1'b0, 10'h008, 32'h0,         32'h0000_00A5, 1'b0};
        vecs[14] = '{1'b1, 10'h024, 32'h0000_0003, 32'h0000_0000, 1'b1};
        vecs[15] = '{1'b0, 10'h024, 32'h0,         32'h0000_0000, 1'b0};

        reset_N = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; addr = '0; pwdata = '0;
        frame_start = 1'b0; status_in = 32'hDEAD_BEEF;
        repeat (3) @(posedge clk);
        #1 reset_N = 1'b1;
        @(posedge clk); #1;
        chk("rst_pready", 64'(pready), 64'd0);
        chk("rst_prdata", 64'(prdata), 64'd0);
        chk("rst_pslverr", 64'(pslverr), 64'd0);
        chk("rst_active", active_cfg, 64'd0);
        chk("rst_commit_done", 64'(commit_done), 64'd0);

        for (int i = 0; i < 16; i++) begin
            apb(vecs[i].wr, vecs[i].a, vecs[i].d, -1, rd, err, lat, cd, late);
            chk($sformatf("v%0d_latency", i), 64'(lat), 64'd3);
            chk($sformatf("v%0d_rdata", i), 64'(rd), 64'(vecs[i].exp_rd));
            chk($sformatf("v%0d_pslverr", i), 64'(err), 64'(vecs[i].exp_err));
            chk($sformatf("v%0d_pready_1cyc", i), 64'(late), 64'd0);
        end
        chk("tbl_active_untouched", active_cfg, 64'd0);

        // Shadow write without COMMIT_REQ: frame_start must not update active.
        apb(1'b1, 10'h000, 32'h33, -1, rd, err, lat, cd, late);
        chk("nocommit_wr_err", 64'(err), 64'd0);
        frame_pulse();
        chk("nocommit_active", active_cfg, 64'd0);
        chk("nocommit_done", 64'(commit_done), 64'd0);
        @(posedge clk); #1;
        chk("nocommit_done2", 64'(commit_done), 64'd0);

        // COMMIT_REQ then frame_start.
        apb(1'b1, 10'h024, 32'h1, -1, rd, err, lat, cd, late);
        chk("ctrl_wr_err", 64'(err), 64'd0);
        apb(1'b0, 10'h024, 32'h0, -1, rd, err, lat, cd, late);
        chk("ctrl_pending_rd", 64'(rd), 64'h2);
        frame_pulse();
        chk("commit_active", active_cfg, 64'h5A00_0000_00A5_0033);
        chk("commit_done_pulse", 64'(commit_done), 64'd1);
        @(posedge clk); #1;
        chk("commit_done_drop", 64'(commit_done), 64'd0);
        apb(1'b0, 10'h024, 32'h0, -1, rd, err, lat, cd, late);
        chk("ctrl_cleared_rd", 64'(rd), 64'h0);

        // Shadow write in RESP coincident with a pending commit.
        apb(1'b1, 10'h004, 32'h11, -1, rd, err, lat, cd, late);
        apb(1'b1, 10'h024, 32'h1, -1, rd, err, lat, cd, late);
        apb(1'b1, 10'h004, 32'h44, 2, rd, err, lat, cd, late);
        chk("coll_wr_err", 64'(err), 64'd0);
        chk("coll_commit_done", 64'(cd), 64'd1);
        chk("coll_active", active_cfg, 64'h5A00_0000_00A5_1133);
        apb(1'b0, 10'h004, 32'h0, -1, rd, err, lat, cd, late);
        chk("coll_shadow_rd", 64'(rd), 64'h44);
        apb(1'b0, 10'h024, 32'h0, -1, rd, err, lat, cd, late);
        chk("coll_ctrl_rd", 64'(rd), 64'h0);

        // COMMIT_REQ in RESP coincident with frame_start: deferred to the next frame.
        apb(1'b1, 10'h024, 32'h1, 2, rd, err, lat, cd, late);
        chk("defer_commit_done", 64'(cd), 64'd0);
        chk("defer_active", active_cfg, 64'h5A00_0000_00A5_1133);
        apb(1'b0, 10'h024, 32'h0, -1, rd, err, lat, cd, late);
        chk("defer_ctrl_rd", 64'(rd), 64'h2);
        frame_pulse();
        chk("defer_active2", active_cfg, 64'h5A00_0000_00A5_4433);
        chk("defer_commit_done2", 64'(commit_done), 64'd1);

        // Reset asserted while the write of idx3 sits in WAIT.
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; addr = 10'h00C; pwdata = 32'h77;
        @(posedge clk); #1;
        penable = 1'b1;
        chk("rstmid_pready_wait", 64'(pready), 64'd0);
        reset_N = 1'b0;
        #1;
        chk("rstmid_pready", 64'(pready), 64'd0);
        chk("rstmid_prdata", 64'(prdata), 64'd0);
        chk("rstmid_pslverr", 64'(pslverr), 64'd0);
        chk("rstmid_active", active_cfg, 64'd0);
        chk("rstmid_commit_done", 64'(commit_done), 64'd0);
        @(posedge clk); #1;
        chk("rstmid_pready2", 64'(pready), 64'd0);
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; reset_N = 1'b1;
        apb(1'b0, 10'h00C, 32'h0, -1, rd, err, lat, cd, late);
        chk("rstmid_idx3_rd", 64'(rd), 64'h0);
        chk("rstmid_idx3_err", 64'(err), 64'd0);
        apb(1'b0, 10'h004, 32'h0, -1, rd, err, lat, cd, late);
        chk("rstmid_idx1_rd", 64'(rd), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
